// File: rtl/specific_sequence_checker.sv
// Receive-side monitor for the 000-001-011-101-111-010 specific-sequence counter.
// Optional macro HOLD_CHECK_EN: flag count_in changes while locked and sample_en=0.
module specific_sequence_checker #(
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             cnt_clr,
  input  logic [2:0]       count_in,
  output logic             locked,
  output logic [2:0]       phase,
  output logic             wrap,
  output logic             seq_error,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       prev_reg, prev_next;
  logic             prev_valid_reg, prev_valid_next;
  logic [2:0]       run_reg, run_next;
  logic [2:0]       phase_reg, phase_next;
  logic             locked_reg, locked_next;
  logic             wrap_reg, wrap_next;
  logic             seq_error_reg, seq_error_next;
  logic [ERR_W-1:0] err_count_reg, err_count_next;
  logic             clr_pending_reg, clr_pending_next;

  logic             forced;
  logic             legal;
  logic [2:0]       expected;
  logic [2:0]       run_inc;

  function automatic logic is_legal(input logic [2:0] c);
    return (c != 3'b100) && (c != 3'b110);
  endfunction

  function automatic logic [2:0] next_code(input logic [2:0] c);
    logic [2:0] n;
    case (c)
      3'b000:  n = 3'b001;
      3'b001:  n = 3'b011;
      3'b011:  n = 3'b101;
      3'b101:  n = 3'b111;
      3'b111:  n = 3'b010;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] phase_of(input logic [2:0] c);
    logic [2:0] p;
    case (c)
      3'b001:  p = 3'd1;
      3'b011:  p = 3'd2;
      3'b101:  p = 3'd3;
      3'b111:  p = 3'd4;
      3'b010:  p = 3'd5;
      default: p = 3'd0;
    endcase
    return p;
  endfunction

  // A clear seen on this edge or on an earlier unsampled edge pins the next sample to 000.
  assign forced   = cnt_clr | clr_pending_reg;
  assign expected = forced ? 3'b000 : next_code(prev_reg);
  assign legal    = is_legal(count_in);
  assign run_inc  = run_reg + 3'd1;

  always_comb begin
    state_next       = state_reg;
    prev_next        = prev_reg;
    prev_valid_next  = prev_valid_reg;
    run_next         = run_reg;
    phase_next       = phase_reg;
    locked_next      = locked_reg;
    wrap_next        = 1'b0;
    seq_error_next   = 1'b0;
    clr_pending_next = clr_pending_reg | cnt_clr;

    if (sample_en) begin
      clr_pending_next = 1'b0;
      case (state_reg)
        ST_HUNT: begin
          if (!legal) begin
            seq_error_next  = 1'b1;
            prev_valid_next = 1'b0;
            run_next        = 3'd0;
          end else begin
            prev_next       = count_in;
            prev_valid_next = 1'b1;
            phase_next      = phase_of(count_in);
            if ((prev_valid_reg || forced) && count_in == expected) begin
              run_next = run_inc;
              if (run_inc == 3'(LOCK_LEN)) begin
                state_next  = ST_LOCKED;
                locked_next = 1'b1;
              end
            end else begin
              run_next = 3'd0;
            end
          end
        end
        ST_LOCKED: begin
          if (count_in == expected) begin
            prev_next  = count_in;
            phase_next = phase_of(count_in);
            wrap_next  = !forced && (prev_reg == 3'b010) && (count_in == 3'b000);
          end else begin
            seq_error_next  = 1'b1;
            locked_next     = 1'b0;
            prev_valid_next = 1'b0;
            run_next        = 3'd0;
            state_next      = ST_ERROR;
          end
        end
        default: begin
          if (legal) begin
            prev_next       = count_in;
            prev_valid_next = 1'b1;
            phase_next      = phase_of(count_in);
            run_next        = 3'd0;
            state_next      = ST_HUNT;
          end else begin
            seq_error_next = 1'b1;
          end
        end
      endcase
    end
`ifdef HOLD_CHECK_EN
    else if (state_reg == ST_LOCKED && !forced && count_in != prev_reg) begin
      seq_error_next  = 1'b1;
      locked_next     = 1'b0;
      prev_valid_next = 1'b0;
      run_next        = 3'd0;
      state_next      = ST_ERROR;
    end
`endif

    err_count_next = err_count_reg;
    if (seq_error_next && err_count_reg != {ERR_W{1'b1}}) begin
      err_count_next = err_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_HUNT;
      prev_reg        <= 3'b000;
      prev_valid_reg  <= 1'b0;
      run_reg         <= 3'd0;
      phase_reg       <= 3'd0;
      locked_reg      <= 1'b0;
      wrap_reg        <= 1'b0;
      seq_error_reg   <= 1'b0;
      err_count_reg   <= '0;
      clr_pending_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      prev_reg        <= prev_next;
      prev_valid_reg  <= prev_valid_next;
      run_reg         <= run_next;
      phase_reg       <= phase_next;
      locked_reg      <= locked_next;
      wrap_reg        <= wrap_next;
      seq_error_reg   <= seq_error_next;
      err_count_reg   <= err_count_next;
      clr_pending_reg <= clr_pending_next;
    end
  end

  assign locked    = locked_reg;
  assign phase     = phase_reg;
  assign wrap      = wrap_reg;
  assign seq_error = seq_error_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_specific_sequence_checker.sv
// Directed self-checking bench: default checker plus a 2-bit error-counter instance.
module tb_specific_sequence_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_en = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [2:0] count_in = 3'b000;
  logic       locked, wrap, seq_error;
  logic [2:0] phase;
  logic [7:0] err_count;

  logic       sat_en = 1'b0;
  logic       sat_clr = 1'b0;
  logic [2:0] sat_cnt = 3'b000;
  logic       sat_locked, sat_wrap, sat_seq_error;
  logic [2:0] sat_phase;
  logic [1:0] sat_err_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  specific_sequence_checker u_dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .cnt_clr(cnt_clr),
    .count_in(count_in), .locked(locked), .phase(phase), .wrap(wrap),
    .seq_error(seq_error), .err_count(err_count)
  );

  specific_sequence_checker #(.LOCK_LEN(3), .ERR_W(2)) u_sat (
    .clk(clk), .reset(reset), .sample_en(sat_en), .cnt_clr(sat_clr),
    .count_in(sat_cnt), .locked(sat_locked), .phase(sat_phase), .wrap(sat_wrap),
    .seq_error(sat_seq_error), .err_count(sat_err_count)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic clr, input logic [2:0] cnt);
    @(negedge clk);
    sample_en = en;
    cnt_clr   = clr;
    count_in  = cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_dut(input string tag, input logic lk, input logic [2:0] ph,
                            input logic wr, input logic se, input logic [7:0] ec);
    chk({tag, ".locked"}, {7'd0, locked}, {7'd0, lk});
    chk({tag, ".phase"}, {5'd0, phase}, {5'd0, ph});
    chk({tag, ".wrap"}, {7'd0, wrap}, {7'd0, wr});
    chk({tag, ".seq_error"}, {7'd0, seq_error}, {7'd0, se});
    chk({tag, ".err_count"}, err_count, ec);
    $display("step %-10s en=%0b clr=%0b cnt=%03b -> locked=%0b phase=%0d wrap=%0b err=%0b cnt=%0d",
             tag, sample_en, cnt_clr, count_in, locked, phase, wrap, seq_error, err_count);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    expect_dut("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // Acquire lock from reset
    step(1, 0, 3'b000); expect_dut("acq000", 0, 0, 0, 0, 0);
    step(1, 0, 3'b001); expect_dut("acq001", 0, 1, 0, 0, 0);
    step(1, 0, 3'b011); expect_dut("acq011", 0, 2, 0, 0, 0);
    step(1, 0, 3'b101); expect_dut("acq101", 1, 3, 0, 0, 0);
    step(1, 0, 3'b111); expect_dut("run111", 1, 4, 0, 0, 0);
    step(1, 0, 3'b010); expect_dut("run010", 1, 5, 0, 0, 0);
    step(1, 0, 3'b000); expect_dut("wrap000", 1, 0, 1, 0, 0);
    step(0, 0, 3'b000); expect_dut("idle", 1, 0, 0, 0, 0);

    // Illegal code while locked, then relock from ERROR
    step(1, 0, 3'b110); expect_dut("ill110", 0, 0, 0, 1, 1);
    step(1, 0, 3'b011); expect_dut("rec011", 0, 2, 0, 0, 1);
    step(1, 0, 3'b101); expect_dut("rec101", 0, 3, 0, 0, 1);
    step(1, 0, 3'b111); expect_dut("rec111", 0, 4, 0, 0, 1);
    step(1, 0, 3'b010); expect_dut("rec010", 1, 5, 0, 0, 1);
    step(1, 0, 3'b000); expect_dut("rwrap", 1, 0, 1, 0, 1);
    step(1, 0, 3'b001); expect_dut("r001", 1, 1, 0, 0, 1);
    step(1, 0, 3'b011); expect_dut("r011", 1, 2, 0, 0, 1);
    step(1, 0, 3'b101); expect_dut("r101", 1, 3, 0, 0, 1);

    // Counter clear at phase 3: 000 accepted without wrap, then 001 rejected
    step(0, 1, 3'b101); expect_dut("clr", 1, 3, 0, 0, 1);
    step(1, 0, 3'b000); expect_dut("clr000", 1, 0, 0, 0, 1);
    step(1, 0, 3'b001); expect_dut("c001", 1, 1, 0, 0, 1);
    step(1, 0, 3'b011); expect_dut("c011", 1, 2, 0, 0, 1);
    step(1, 0, 3'b101); expect_dut("c101", 1, 3, 0, 0, 1);
    step(1, 1, 3'b001); expect_dut("clr001", 0, 3, 0, 1, 2);

    // Relock then stall (repeated value)
    step(1, 0, 3'b011); expect_dut("s011", 0, 2, 0, 0, 2);
    step(1, 0, 3'b101); expect_dut("s101", 0, 3, 0, 0, 2);
    step(1, 0, 3'b111); expect_dut("s111", 0, 4, 0, 0, 2);
    step(1, 0, 3'b010); expect_dut("s010", 1, 5, 0, 0, 2);
    step(1, 0, 3'b010); expect_dut("stall", 0, 5, 0, 1, 3);

    // Relock; wrap must not pulse while still hunting
    step(1, 0, 3'b111); expect_dut("h111", 0, 4, 0, 0, 3);
    step(1, 0, 3'b010); expect_dut("h010", 0, 5, 0, 0, 3);
    step(1, 0, 3'b000); expect_dut("h000", 0, 0, 0, 0, 3);
    step(1, 0, 3'b001); expect_dut("h001", 1, 1, 0, 0, 3);

    // Saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      sat_en  = 1'b1;
      sat_cnt = 3'b100;
      step(0, 0, 3'b001);
      chk($sformatf("sat%0d.err_count", i), {6'd0, sat_err_count}, (i < 3) ? 8'(i + 1) : 8'd3);
      chk($sformatf("sat%0d.seq_error", i), {7'd0, sat_seq_error}, 8'd1);
      $display("sat %0d cnt=100 -> err=%0b err_count=%0d", i, sat_seq_error, sat_err_count);
      expect_dut($sformatf("satdut%0d", i), 1, 1, 0, 0, 3);
    end
    sat_en = 1'b0;

    // Asynchronous reset mid-run, checked between clock edges
    #3;
    reset = 1'b0;
    #1;
    expect_dut("areset", 0, 0, 0, 0, 0);
    chk("areset.sat_err_count", {6'd0, sat_err_count}, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // Lock with last accepted code 011, then change count_in while idle
    step(1, 0, 3'b010); expect_dut("l010", 0, 5, 0, 0, 0);
    step(1, 0, 3'b000); expect_dut("l000", 0, 0, 0, 0, 0);
    step(1, 0, 3'b001); expect_dut("l001", 0, 1, 0, 0, 0);
    step(1, 0, 3'b011); expect_dut("l011", 1, 2, 0, 0, 0);
    step(0, 0, 3'b101);
`ifdef HOLD_CHECK_EN
    expect_dut("hold", 0, 2, 0, 1, 1);
`else
    expect_dut("hold", 1, 2, 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/specific_sequence_checker.md
Name: specific_sequence_checker

Overview:
- Receive-side monitor for the lab-7 specific-sequence 3-bit counter.
- Watches the counter's count bus and confirms it steps through the fixed sequence 000→001→011→101→111→010→000.
- Locks onto the sequence, reports position and wrap, and flags and counts illegal codes or illegal transitions.
- Sits beside the counter in the lab top level and testbenches as a self-checking receiver.

Parameters:
- LOCK_LEN, 3: consecutive legal transitions required to assert locked (1..7).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (clears all state when 0).
- sample_en  input  1  count_in holds a new counter value this cycle. Integrator drives it as counter enable delayed one clk.
- cnt_clr  input  1  counter was synchronously cleared. Next sample must be 000.
- count_in  input  3  counter output under test.
- locked  output  1  sequence tracking established.
- phase  output  3  index of last accepted code in the sequence, 0..5 (000=0, 001=1, 011=2, 101=3, 111=4, 010=5).
- wrap  output  1  one-cycle pulse when 010→000 is accepted while locked.
- seq_error  output  1  one-cycle pulse on a detected violation.
- err_count  output  ERR_W  saturating count of seq_error pulses.

Behaviour:
- All outputs are registered; response appears the cycle after the sampling edge.
- Reset (reset=0, async): state=HUNT, locked=0, phase=0, wrap=0, seq_error=0, err_count=0, run counter=0, prev valid=0.
- Legal codes: {000, 001, 011, 101, 111, 010}. Illegal codes: 100 and 110.
- next() maps each legal code to its successor; 010 maps to 000.
- Samples are taken only on edges with sample_en=1. With sample_en=0, state and phase hold, and wrap and seq_error are 0.
- FSM states: HUNT, LOCKED, ERROR.
- HUNT:
  - Illegal code → seq_error pulse, prev valid cleared, run=0.
  - Legal code with no valid prev → capture it, run=0.
  - Legal code that equals next(prev) → run+1. When run reaches LOCK_LEN, go to LOCKED and set locked=1.
  - Legal code that does not equal next(prev) → recapture the code, run=0, no error.
- LOCKED:
  - count_in == next(prev) → accept and update phase. Pulse wrap on 010→000.
  - Any other value → seq_error pulse, locked=0, go to ERROR.
- ERROR: lasts one sample. A legal code is captured as the new prev and the FSM goes to HUNT with run=0. An illegal code gives another seq_error pulse and the FSM stays in ERROR.
- cnt_clr=1 on a clock edge: expected next sample is forced to 000 and locked is kept.
  - If sample_en is also 1 on that edge, the sample must be 000. A 000 sample is accepted as phase 0 with no wrap. Any other value is an error.
- err_count increments on each seq_error and saturates at all-ones.
- A repeated value with sample_en=1 (counter stalled while claimed advancing) is an error when LOCKED.
- Reset mid-sequence returns to HUNT immediately and asynchronously. The first edge after release may sample.

Optional Feature:
- Macro HOLD_CHECK_EN.
- Defined: while LOCKED and sample_en=0, any change of count_in from the last accepted code pulses seq_error, increments err_count and moves to ERROR.
- Undefined: count_in is ignored whenever sample_en=0.

Test Plan:
- Reset low, then release. Drive 000,001,011,101 with sample_en=1 → locked=1 the cycle after the 101 sample, phase=3, err_count=0.
- While locked, drive 111,010,000 → phase 4,5,0; one wrap pulse after the 000 sample; seq_error stays 0.
- While locked, inject 110 → seq_error pulse, locked=0, err_count=1. Then 011,101,111,010 → locked=1 again after 010.
- Assert cnt_clr at phase 3, then sample 000 → no error, phase=0, locked held. Repeating with sample 001 → seq_error, err_count+1.
- ERR_W=2, drive five illegal samples → err_count=3 (saturated). Pull reset low mid-run → err_count=0 and locked=0 immediately, without a clock.
- With HOLD_CHECK_EN defined, locked at 011 and sample_en=0, change count_in to 101 → seq_error. Without the macro → no error.
